// File: rtl/snake_body_pkg.sv
// snake_body_pkg: playfield size, heading encoding and coordinate helpers shared by the snake body blocks.
package snake_body_pkg;
    localparam int GAME_WIDTH = 20;
    localparam int GAME_HEIGHT = 13;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic {STREAM, UPDATE} state_t;
    typedef struct packed {
        logic [4:0] x;
        logic [3:0] y;
    } pos_t;
    function automatic dir_t dir_opposite(dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction
    // Deltas are two's complement so a plain modular add moves one cell.
    function automatic pos_t dir_step(dir_t d);
        return (d == UP)   ? pos_t'({5'd0, 4'hF}) :
               (d == DOWN) ? pos_t'({5'd0, 4'd1}) :
               (d == LEFT) ? pos_t'({5'h1F, 4'd0}) :
                             pos_t'({5'd1, 4'd0});
    endfunction
endpackage

// File: rtl/snake_body_if.sv
// snake_body_if: per-segment stream from the snake body to the VGA renderer.
interface snake_body_if;
    logic [4:0] snake_x;
    logic [3:0] snake_y;
    logic [1:0] snake_dir;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;
    modport master (output snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid);
    modport slave (input snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid);
endinterface

// File: rtl/snake_body_ring.sv
// snake_ring: ring of tailward link directions with a head pointer; push at head, read at an offset behind it.
module snake_ring import snake_body_pkg::*; #(
    parameter int MAX_LEN = 32,
    localparam int PW = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  dir_t          push_dir,
    input  logic [PW-1:0] rd_off,
    output dir_t          rd_dir
);
    dir_t          mem [MAX_LEN];
    logic [PW-1:0] head_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: LEFT};
            head_ptr <= '0;
        end else if (clr) begin
            mem <= '{default: LEFT};
            head_ptr <= '0;
        end else if (push) begin
            mem[head_ptr + PW'(1)] <= push_dir;
            head_ptr <= head_ptr + PW'(1);
        end
    end
    assign rd_dir = mem[head_ptr - rd_off];
endmodule

// File: rtl/snake_body.sv
// snake_body: snake head + link ring, streamed head-to-tail each pass; applies steps between passes.
// Define SNAKE_WRAP_EN to wrap the head at the walls instead of failing.
module snake_body import snake_body_pkg::*; #(
    parameter int MAX_LEN = 32,
    parameter int INIT_LEN = 3,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int PW = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          game_rst_n,
    input  logic          step,
    input  logic [1:0]    dir,
    input  logic          grow,
    snake_body_if.master  sb,
    output logic [4:0]    snake_head_x,
    output logic [3:0]    snake_head_y,
    output logic [LW-1:0] length,
    output logic          step_done,
    output logic          failure,
    output logic          success
);
    typedef struct packed {
        pos_t          head;
        pos_t          walk;
        logic [LW-1:0] len;
        logic [PW-1:0] k;
        logic          pending;
        logic          p_grow;
        logic [1:0]    p_dir;
        logic          took;
        logic          done;
        logic          fail;
        logic          succ;
        pos_t          out_pos;
        logic [1:0]    out_dir;
        logic          first;
        logic          last;
        logic          valid;
    } regs_t;
    localparam regs_t R0 = '{head: pos_t'({5'(INIT_LEN), 4'((GAME_HEIGHT + 1) / 2)}),
                             len: LW'(INIT_LEN), default: '0};
    function automatic pos_t move(pos_t p, dir_t d);
        pos_t dl, q;
        dl = dir_step(d);
        q.x = p.x + dl.x;
        q.y = p.y + dl.y;
`ifdef SNAKE_WRAP_EN
        q.x = (q.x == 5'(GAME_WIDTH + 1)) ? 5'd1 : (q.x == 5'd0) ? 5'(GAME_WIDTH) : q.x;
        q.y = (q.y == 4'(GAME_HEIGHT + 1)) ? 4'd1 : (q.y == 4'd0) ? 4'(GAME_HEIGHT) : q.y;
`endif
        return q;
    endfunction
    state_t state, state_n;
    regs_t  r, r_n;
    dir_t   rd_dir, eff_dir;
    pos_t   cur, new_head;
    logic   last_seg, in_range, take, commit;
    snake_ring #(.MAX_LEN(MAX_LEN)) u_ring (
        .clk(clk), .rst_n(rst_n), .clr(!game_rst_n), .push(commit),
        .push_dir(dir_opposite(eff_dir)), .rd_off(r.k), .rd_dir(rd_dir)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UPDATE;
        else state <= game_rst_n ? state_n : UPDATE;
    end
    always_comb begin
        state_n = (state == UPDATE) ? STREAM : last_seg ? UPDATE : STREAM;
    end
    // In UPDATE k is zero, so the ring read port returns the head link.
    always_comb begin
        r_n = r;
        cur = (r.k == '0) ? r.head : r.walk;
        last_seg = (state == STREAM) && (LW'(r.k) == r.len - LW'(1));
        eff_dir = (r.p_dir == rd_dir) ? dir_opposite(rd_dir) : dir_t'(r.p_dir);
        new_head = move(r.head, eff_dir);
        in_range = new_head.x >= 5'd1 && new_head.x <= 5'(GAME_WIDTH) &&
                   new_head.y >= 4'd1 && new_head.y <= 4'(GAME_HEIGHT);
        take = (state == UPDATE) && r.pending;
        commit = take && !r.fail && !r.succ && in_range;
        r_n.valid = state == STREAM;
        r_n.first = (state == STREAM) && (r.k == '0);
        r_n.last = last_seg;
        r_n.out_pos = cur;
        r_n.out_dir = rd_dir;
        r_n.walk = move(cur, rd_dir);
        r_n.k = (state == STREAM && !last_seg) ? r.k + PW'(1) : '0;
        r_n.fail = r.fail || (state == STREAM && r.k != '0 && cur == r.head) ||
                   (take && !r.fail && !r.succ && !in_range);
        r_n.head = commit ? new_head : r.head;
        r_n.len = (commit && r.p_grow) ? r.len + LW'(1) : r.len;
        r_n.succ = r.succ || (commit && r.p_grow && r.len == LW'(MAX_LEN - 1));
        r_n.took = take;
        r_n.done = r.took;
        r_n.pending = step || (r.pending && !take);
        r_n.p_dir = step ? dir : r.p_dir;
        r_n.p_grow = step ? grow : r.p_grow;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= R0;
        else r <= game_rst_n ? r_n : R0;
    end
    assign sb.snake_x = r.out_pos.x;
    assign sb.snake_y = r.out_pos.y;
    assign sb.snake_dir = r.out_dir;
    assign sb.snake_first = r.first;
    assign sb.snake_last = r.last;
    assign sb.snake_valid = r.valid;
    assign snake_head_x = r.head.x;
    assign snake_head_y = r.head.y;
    assign length = r.len;
    assign step_done = r.done;
    assign failure = r.fail;
    assign success = r.succ;
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed test-plan scenarios plus random play, checked every cycle against a position-queue model.
module tb_snake_body;
    import snake_body_pkg::*;
    localparam int MAX_LEN = 32;
    localparam int INIT_LEN = 3;
    localparam int HY = (GAME_HEIGHT + 1) / 2;
    logic clk = 0, rst_n, game_rst_n, step, grow;
    logic [1:0] dir;
    logic [4:0] head_x;
    logic [3:0] head_y;
    logic [5:0] length;
    logic step_done, failure, success;
    snake_body_if sb_if ();
    snake_body #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n), .step(step), .dir(dir), .grow(grow),
        .sb(sb_if), .snake_head_x(head_x), .snake_head_y(head_y), .length(length),
        .step_done(step_done), .failure(failure), .success(success)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endfunction
    // Model: body as a queue of positions (head first) plus tailward links.
    int qx[$], qy[$], ql[$];
    bit m_upd, m_pend, m_pgrow, m_took;
    int m_k, m_pdir;
    bit e_valid, e_first, e_last, e_done, e_fail, e_succ;
    int e_x, e_y, e_dir;
    function automatic void m_init();
        qx.delete(); qy.delete(); ql.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            qx.push_back(INIT_LEN - i);
            qy.push_back(HY);
            if (i < INIT_LEN - 1) ql.push_back(2);
        end
        m_upd = 1; m_k = 0; m_pend = 0; m_pgrow = 0; m_pdir = 0; m_took = 0;
        e_valid = 0; e_first = 0; e_last = 0; e_done = 0; e_fail = 0; e_succ = 0;
        e_x = 0; e_y = 0; e_dir = 0;
    endfunction
    function automatic void apply_move();
        int d, nx, ny;
        d = (m_pdir == ql[0]) ? (ql[0] ^ 1) : m_pdir;
        nx = qx[0] + (d == 2 ? -1 : d == 3 ? 1 : 0);
        ny = qy[0] + (d == 0 ? -1 : d == 1 ? 1 : 0);
`ifdef SNAKE_WRAP_EN
        if (nx == GAME_WIDTH + 1) nx = 1;
        if (nx == 0) nx = GAME_WIDTH;
        if (ny == GAME_HEIGHT + 1) ny = 1;
        if (ny == 0) ny = GAME_HEIGHT;
`else
        if (nx < 1 || nx > GAME_WIDTH || ny < 1 || ny > GAME_HEIGHT) begin
            e_fail = 1;
            return;
        end
`endif
        qx.push_front(nx); qy.push_front(ny); ql.push_front(d ^ 1);
        if (m_pgrow) begin
            if (qx.size() == MAX_LEN) e_succ = 1;
        end else begin
            void'(qx.pop_back()); void'(qy.pop_back()); void'(ql.pop_back());
        end
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !game_rst_n) m_init();
        else begin
            e_done = m_took;
            m_took = 0;
            if (m_upd) begin
                e_valid = 0; e_first = 0; e_last = 0;
                if (m_pend) begin
                    m_took = 1; m_pend = 0;
                    if (!(e_fail || e_succ)) apply_move();
                end
                m_upd = 0; m_k = 0;
            end else begin
                e_valid = 1; e_first = (m_k == 0); e_last = (m_k == qx.size() - 1);
                e_x = qx[m_k]; e_y = qy[m_k];
                e_dir = (m_k < qx.size() - 1) ? ql[m_k] : -1;
                if (m_k > 0 && qx[m_k] == qx[0] && qy[m_k] == qy[0]) e_fail = 1;
                if (m_k == qx.size() - 1) m_upd = 1; else m_k++;
            end
            if (step) begin m_pend = 1; m_pdir = dir; m_pgrow = grow; end
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", sb_if.snake_valid, e_valid);
            chk("head_x", head_x, qx[0]);
            chk("head_y", head_y, qy[0]);
            chk("length", length, qx.size());
            chk("step_done", step_done, e_done);
            chk("failure", failure, e_fail);
            chk("success", success, e_succ);
            if (e_valid) begin
                chk("seg_x", sb_if.snake_x, e_x);
                chk("seg_y", sb_if.snake_y, e_y);
                chk("seg_first", sb_if.snake_first, e_first);
                chk("seg_last", sb_if.snake_last, e_last);
                if (e_dir >= 0) chk("seg_dir", sb_if.snake_dir, e_dir);
            end
        end
    end
    task automatic pulse_step(input int d, input bit g);
        @(negedge clk); step = 1; dir = 2'(d); grow = g;
        @(negedge clk); step = 0;
    endtask
    task automatic do_step(input int d, input bit g);
        int seen = 0;
        pulse_step(d, g);
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = step_done;
        end
        chk("step_done_seen", seen, 1);
    endtask
    task automatic wait_seg(input bit want_first);
        int seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = sb_if.snake_valid && (want_first ? sb_if.snake_first : !sb_if.snake_first && !sb_if.snake_last);
        end
        chk("segment_seen", seen, 1);
    endtask
    task automatic game_reset();
        @(negedge clk); game_rst_n = 0;
        @(negedge clk); game_rst_n = 1;
    endtask
    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int seen;
        rst_n = 0; game_rst_n = 1; step = 0; dir = 0; grow = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", sb_if.snake_valid, 0);
        chk("rst_x", sb_if.snake_x, 0);
        chk("rst_head_x", head_x, 3);
        chk("rst_head_y", head_y, 7);
        chk("rst_length", length, 3);
        chk("rst_failure", failure, 0);
        rst_n = 1;
        wait_seg(1);
        chk("p0_x", sb_if.snake_x, 3); chk("p0_y", sb_if.snake_y, 7); chk("p0_dir", sb_if.snake_dir, 2);
        @(negedge clk);
        chk("p1_x", sb_if.snake_x, 2); chk("p1_dir", sb_if.snake_dir, 2);
        @(negedge clk);
        chk("p2_x", sb_if.snake_x, 1); chk("p2_last", sb_if.snake_last, 1);
        @(negedge clk);
        chk("gap_valid", sb_if.snake_valid, 0);
        @(negedge clk);
        chk("period_first", sb_if.snake_first, 1);
        do_step(3, 0);
        chk("right_head_x", head_x, 4); chk("right_length", length, 3);
        do_step(2, 0);
        chk("reverse_head_x", head_x, 5);
        repeat (15) do_step(3, 0);
        chk("edge_head_x", head_x, GAME_WIDTH);
        do_step(3, 0);
`ifdef SNAKE_WRAP_EN
        chk("wrap_head_x", head_x, 1); chk("wrap_failure", failure, 0);
`else
        chk("wall_head_x", head_x, GAME_WIDTH); chk("wall_failure", failure, 1);
`endif
        game_reset();
        repeat (15) do_step(3, 1);
        repeat (2) do_step(1, 1);
        repeat (12) do_step(2, 1);
        chk("full_length", length, 32); chk("full_success", success, 1);
        do_step(0, 0);
        chk("full_head_x", head_x, 6); chk("full_head_y", head_y, 9);
        game_reset();
        repeat (2) do_step(3, 1);
        do_step(0, 0); do_step(2, 0); do_step(1, 0);
        seen = 0;
        for (int i = 0; i < 14 && !seen; i++) begin
            @(negedge clk);
            seen = failure;
        end
        chk("self_collision", seen, 1);
        wait_seg(0);
        game_rst_n = 0;
        @(negedge clk); game_rst_n = 1;
        chk("grst_valid", sb_if.snake_valid, 0);
        chk("grst_head_x", head_x, 3);
        chk("grst_length", length, 3);
        chk("grst_failure", failure, 0);
        for (int ep = 0; ep < 10; ep++) begin
            game_reset();
            for (int s = 0; s < 50; s++) begin
                pulse_step($urandom_range(0, 3), $urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 7)) @(negedge clk);
            end
        end
        repeat (40) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
